uart_ack_receiver_endpoint: RTL and testbench

//  Far-end terminator for the slave-side "send" UART link: consumes bytes from a uart_receiver,

---
 rtl/uart_ack_receiver_endpoint.sv | 187 ++++++++++++++++++
 tb/tb_uart_ack_receiver_endpoint.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ack_receiver_endpoint.sv
// -----------------------------------------------------------------------------
// uart_ack_receiver_endpoint
//
// Far-end terminator for the slave-side "send" UART link. Every byte delivered
// by the uart_receiver is either buffered in a first-word-fall-through FIFO for
// the local consumer or dropped when the FIFO is full. The byte is then answered
// with ACK_BYTE (buffered) or NACK_BYTE (dropped) through the uart_transmitter.
//
// Ports
//   clk          system clock
//   rstN         asynchronous active-low reset
//   rxDone       1-cycle pulse: byteFromRx is valid
//   byteFromRx   received byte
//   txReady      uart_transmitter idle
//   txStart      1-cycle start pulse to uart_transmitter
//   byteForTx    response byte being sent; held until the next response
//   out_data     FIFO head (valid while out_valid = 1, otherwise 0)
//   out_valid    FIFO not empty
//   out_ready    consumer pops the head when out_valid && out_ready
//   fill_count   current FIFO occupancy, 0..FIFO_DEPTH
//   overrun      sticky: a response was discarded because one was still pending
//   clr_overrun  synchronous clear of overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_ack_receiver_endpoint #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] ACK_BYTE   = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] NACK_BYTE  = 8'h5A
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          rxDone,
    input  logic [DATA_WIDTH-1:0]         byteFromRx,
    input  logic                          txReady,
    output logic                          txStart,
    output logic [DATA_WIDTH-1:0]         byteForTx,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_count,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_DRAIN
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Response path
    state_t                state;
    state_t                state_next;
    logic                  load_go;
    logic                  busy_cnt;
    logic                  pend_valid;
    logic                  pend_is_ack;
    logic                  overrun_set;

    // ---------------------------------------------------------------- FIFO
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = out_ready && !empty;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push  = rxDone && (!full || pop);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Data storage carries no reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= byteFromRx;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fill_count = count;

    // ---------------------------------------------------------------- response FSM
    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_valid && txReady) begin
                    load_go    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_BUSY;
            end
            S_BUSY: begin
                // Leave once the transmitter drops txReady, or give up after
                // two cycles in case it never visibly went busy.
                if (!txReady || busy_cnt) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (txReady) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A new byte while the previous response is still waiting (and not being
    // taken this cycle) loses its response; the sender will time out.
    assign overrun_set = rxDone && pend_valid && !load_go;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= S_IDLE;
            busy_cnt    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_is_ack <= 1'b0;
            txStart     <= 1'b0;
            byteForTx   <= '0;
            overrun     <= 1'b0;
        end else begin
            state    <= state_next;
            busy_cnt <= (state == S_BUSY);

            // txStart is a register so it can never glitch; it is high for
            // exactly the one cycle spent in S_LOAD.
            txStart <= load_go;
            if (load_go) begin
                byteForTx <= pend_is_ack ? ACK_BYTE : NACK_BYTE;
            end

            // Setting the pending response wins over LOAD consuming it.
            if (rxDone && !overrun_set) begin
                pend_valid  <= 1'b1;
                pend_is_ack <= push;
            end else if (load_go) begin
                pend_valid  <= 1'b0;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_ack_receiver_endpoint.sv
`timescale 1ns/1ps

module tb_uart_ack_receiver_endpoint;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxDone = 1'b0;
    logic [7:0] byteFromRx = 8'h00;
    logic       txReady;
    logic       txStart;
    logic [7:0] byteForTx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] fill_count;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int errors = 0;
    int checks = 0;

    // Simple transmitter model: busy for 4 cycles after each start pulse.
    // hold_tx forces it to look busy.
    logic       hold_tx = 1'b0;
    int         tx_cnt = 0;
    int         n_resp = 0;
    int         n_ack = 0;
    int         n_nack = 0;
    logic [7:0] last_resp = 8'h00;

    assign txReady = !hold_tx && (tx_cnt == 0);

    always #5 clk = ~clk;

    uart_ack_receiver_endpoint #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(16),
        .ACK_BYTE  (8'hA5),
        .NACK_BYTE (8'h5A)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .rxDone     (rxDone),
        .byteFromRx (byteFromRx),
        .txReady    (txReady),
        .txStart    (txStart),
        .byteForTx  (byteForTx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always @(negedge clk) begin
        if (txStart) begin
            n_resp++;
            last_resp = byteForTx;
            if (byteForTx == 8'hA5) n_ack++;
            else if (byteForTx == 8'h5A) n_nack++;
            tx_cnt = 4;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxDone     = 1'b1;
        byteFromRx = b;
        tick();
        rxDone     = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int   base;
        int   base_r;
        int   base_n;
        logic found;
        logic [7:0] b;

        // Reset state
        tick(2);
        chk("rst_txStart", txStart, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill", fill_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_byteForTx", byteForTx, 0);
        rstN = 1'b1;
        tick();

        // Single byte: txStart two cycles after rxDone, FWFT head visible
        send_byte(8'h3C);
        chk("t2_txStart_early", txStart, 0);
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_data", out_data, 8'h3C);
        chk("t2_fill", fill_count, 1);
        tick();
        chk("t2_txStart", txStart, 1);
        chk("t2_byteForTx", byteForTx, 8'hA5);
        tick();
        chk("t2_txStart_pulse", txStart, 0);
        tick(10);
        pop_one();
        chk("t2_fill_after_pop", fill_count, 0);
        chk("t2_out_valid_after_pop", out_valid, 0);
        chk("t2_acks", n_ack, 1);

        // Fill to 16, then a 17th byte is dropped with NACK
        base = n_ack;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            tick(12);
        end
        chk("t3_fill16", fill_count, 16);
        chk("t3_acks16", n_ack - base, 16);
        send_byte(8'hFF);
        chk("t3_fill_after_drop", fill_count, 16);
        tick(12);
        chk("t3_nack_byte", last_resp, 8'h5A);
        chk("t3_nacks", n_nack, 1);
        chk("t3_head", out_data, 8'h00);

        // Full + simultaneous pop and rxDone: accepted, count unchanged
        out_ready = 1'b1;
        send_byte(8'h77);
        out_ready = 1'b0;
        chk("t4_fill", fill_count, 16);
        tick(12);
        chk("t4_ack_byte", last_resp, 8'hA5);
        chk("t4_acks", n_ack - base, 17);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t3_drain_%0d", i), out_data, i);
            pop_one();
        end
        chk("t4_drain_last", out_data, 8'h77);
        pop_one();
        chk("t3_fill_empty", fill_count, 0);
        chk("t3_nacks_final", n_nack, 1);

        // Overrun: second rxDone while the first response is still pending
        hold_tx = 1'b1;
        base_r  = n_resp;
        send_byte(8'h11);
        tick(2);
        send_byte(8'h22);
        chk("t5_overrun", overrun, 1);
        chk("t5_fill", fill_count, 2);
        tick(5);
        chk("t5_no_resp_while_busy", n_resp - base_r, 0);
        hold_tx = 1'b0;
        tick(12);
        chk("t5_one_resp", n_resp - base_r, 1);
        chk("t5_resp_ack", last_resp, 8'hA5);
        chk("t5_overrun_sticky", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t5_overrun_clr", overrun, 0);
        chk("t5_head0", out_data, 8'h11);
        pop_one();
        chk("t5_head1", out_data, 8'h22);
        pop_one();
        chk("t5_fill_empty", fill_count, 0);

        // Wrap: 40 bytes with continuous pop
        out_ready = 1'b1;
        base   = n_ack;
        base_n = n_nack;
        for (int i = 0; i < 40; i++) begin
            b = 8'(i * 7 + 3);
            send_byte(b);
            chk($sformatf("t6_data_%0d", i), out_data, b);
            tick(11);
        end
        out_ready = 1'b0;
        chk("t6_fill", fill_count, 0);
        chk("t6_acks", n_ack - base, 40);
        chk("t6_nacks", n_nack - base_n, 0);

        // Reset mid-BUSY with data buffered and overrun set
        hold_tx = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        chk("t1_pre_overrun", overrun, 1);
        chk("t1_pre_fill", fill_count, 2);
        hold_tx = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (txStart) found = 1'b1;
            else tick();
        end
        chk("t1_txStart_seen", found, 1);
        tick();
        rstN = 1'b0;
        #1;
        chk("t1_txStart", txStart, 0);
        chk("t1_out_valid", out_valid, 0);
        chk("t1_fill", fill_count, 0);
        chk("t1_overrun", overrun, 0);
        chk("t1_byteForTx", byteForTx, 0);
        base_r = n_resp;
        tick(3);
        chk("t1_no_start_in_reset", n_resp - base_r, 0);
        rstN = 1'b1;
        tick(2);
        chk("t1_idle_after_reset", txStart, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
